mp_subtractor: RTL and testbench
================================

MP_SUBTRACTOR -- requirements
Module: mp_subtractor

Interface
REQ-001 SHALL have parameter OPERAND_WIDTH, default 512: operand width in bits; must be an integer multiple of ADDER_WIDTH.
REQ-002 SHALL have parameter ADDER_WIDTH, default 64: width of one word, processed per cycle.
REQ-003 SHALL have parameter N_ITERATIONS, default OPERAND_WIDTH/ADDER_WIDTH: number of words.
REQ-004 SHALL have port iClk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port iRst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port iStart, input, 1 bit: request to start one subtraction; sampled only in IDLE.
REQ-007 SHALL have port iOpA, input, OPERAND_WIDTH bits: minuend, unsigned.
REQ-008 SHALL have port iOpB, input, OPERAND_WIDTH bits: subtrahend, unsigned.
REQ-009 SHALL have port oRes, output, OPERAND_WIDTH bits: (A - B) mod 2^OPERAND_WIDTH.
REQ-010 SHALL have port oBorrow, output, 1 bit: 1 iff A < B.
REQ-011 SHALL have port oBusy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port oDone, output, 1 bit: one-cycle pulse; oRes and oBorrow are valid while it is high.

Function
REQ-013 SHALL compute A - B word-serially as A + ~B + 1, least significant word first.
REQ-014 SHALL use four states: IDLE, SUB_FIRST, SUB_WORDS, DONE.
REQ-015 SHALL, in IDLE with iStart=1 at a rising edge, capture iOpA and iOpB into internal shift registers, clear the word counter, and go to SUB_FIRST.
REQ-016 SHALL, in SUB_FIRST, add word 0 of A to the inverted word 0 of B with carry-in forced to 1, then go to SUB_WORDS; N_ITERATIONS=1 goes directly to DONE instead.
REQ-017 SHALL, in SUB_WORDS, add word i of A to the inverted word i of B with carry-in taken from the registered carry of word i-1.
REQ-018 SHALL, in SUB_WORDS, stay in SUB_WORDS until word N_ITERATIONS-1 has been processed, then go to DONE.
REQ-019 SHALL, on each SUB edge, shift the operand registers right by ADDER_WIDTH with zero fill.
REQ-020 SHALL, on each SUB edge, load the sum word into the MSB word of the result register, shifting the remaining result words right by one word.
REQ-021 SHALL drive oDone high for exactly the one cycle spent in DONE, which follows the N_ITERATIONS-th rising edge after the edge that sampled iStart; the FSM then returns to IDLE.
REQ-022 SHALL set oBorrow to the inverse of the carry-out of the final word, registered on that word's edge.
REQ-023 SHALL hold oRes and oBorrow unchanged from DONE until the next accepted start.
REQ-024 SHALL ignore iStart whenever the FSM is not in IDLE; operands are not recaptured and the current operation is not disturbed.
REQ-025 SHALL accept iStart held high in the DONE cycle on the edge after it returns to IDLE; back-to-back operations have one IDLE cycle between them.
REQ-026 SHALL have all outputs driven from registers or the state register, with no combinational path from any input to any output.

Reset
REQ-027 SHALL, on iRst=1 at any time including mid-operation, immediately clear the state to IDLE and clear the counter, operand, result and carry registers to 0.
REQ-028 SHALL, while reset is active, hold oRes=0, oBorrow=0, oBusy=0 and oDone=0.
REQ-029 SHALL never assert oDone for an operation interrupted by reset.

Structure
REQ-030 SHALL take the state encodings (IDLE=2'd0, SUB_FIRST=2'd1, SUB_WORDS=2'd2, DONE=2'd3) and the default width constants from shared package mp_arith_pkg.
REQ-031 SHALL instantiate one sub-module, carry_select_adder_ripple (ADDER_WIDTH-bit), with its B input fed by the inverted B word.
REQ-032 SHALL size the counter as $clog2(N_ITERATIONS)+1 bits.

Verification (OPERAND_WIDTH=512, ADDER_WIDTH=64)
REQ-033 SHALL cover: A=5, B=3, start pulse -> oDone one cycle after the 8th edge following start, oRes=2, oBorrow=0, oBusy low the next cycle.
REQ-034 SHALL cover: A=0, B=1 -> oRes all 512 bits set, oBorrow=1.
REQ-035 SHALL cover: A=2^64, B=1 (borrow across words) -> word0=64'hFFFF_FFFF_FFFF_FFFF, words1..7=0, oBorrow=0.
REQ-036 SHALL cover: A=B=all ones -> oRes=0, oBorrow=0.
REQ-037 SHALL cover: iStart pulsed with new operands 3 cycles into an operation -> first result unchanged, exactly one oDone pulse.
REQ-038 SHALL cover: iRst asserted for 1 cycle after the 4th SUB edge -> outputs 0 immediately, no oDone, then a fresh start A=9, B=4 yields oRes=5.

Source files
------------

// File: rtl/mp_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mp_arith_pkg
//  Description : Shared definitions for the multi-precision arithmetic
//                blocks: FSM state encoding and default width constants.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mp_arith_pkg;

   // Sequencer states of the word-serial arithmetic units.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SUB_FIRST = 2'd1,
      SUB_WORDS = 2'd2,
      DONE      = 2'd3
   } mp_state_t;

   // Default operand and word widths.
   localparam int unsigned MP_OPERAND_WIDTH   = 512;
   localparam int unsigned MP_ADDER_WIDTH     = 64;

   // Block size of the carry-select stages inside the word adder.
   localparam int unsigned MP_CSA_BLOCK_WIDTH = 16;

endpackage : mp_arith_pkg
`default_nettype wire

// File: rtl/carry_select_adder_ripple.sv
`default_nettype none
// ============================================================================
//  Module      : carry_select_adder_ripple
//  Description : Combinational WIDTH-bit adder. The word is split into
//                ripple-carry blocks; every block above the lowest computes
//                its sum for both carry-in values and the real carry picks
//                one. Falls back to a plain ripple adder when WIDTH is not a
//                multiple of BLOCK_WIDTH (or fits in a single block).
//  Ports       : iA    - addend A
//                iB    - addend B
//                iCin  - carry-in
//                oSum  - (iA + iB + iCin) mod 2^WIDTH
//                oCout - carry-out of the most significant bit
//  Revision    : 1.0 - initial release
// ============================================================================
module carry_select_adder_ripple
   import mp_arith_pkg::*;
#(
   parameter int unsigned WIDTH       = MP_ADDER_WIDTH,
   parameter int unsigned BLOCK_WIDTH = MP_CSA_BLOCK_WIDTH
) (
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   input  logic             iCin,
   output logic [WIDTH-1:0] oSum,
   output logic             oCout
);

   generate
      if ((WIDTH > BLOCK_WIDTH) && ((WIDTH % BLOCK_WIDTH) == 0)) begin : g_carrySelect
         localparam int unsigned N_BLOCKS = WIDTH / BLOCK_WIDTH;

         logic [N_BLOCKS:0] w_carry;

         assign w_carry[0] = iCin;

         // Lowest block sees the true carry-in directly; no selection needed.
         assign {w_carry[1], oSum[BLOCK_WIDTH-1:0]} =
            {1'b0, iA[BLOCK_WIDTH-1:0]} + {1'b0, iB[BLOCK_WIDTH-1:0]} +
            {{BLOCK_WIDTH{1'b0}}, iCin};

         for (genvar k = 1; k < N_BLOCKS; k++) begin : g_block
            logic [BLOCK_WIDTH:0] w_sum0;
            logic [BLOCK_WIDTH:0] w_sum1;

            assign w_sum0 = {1'b0, iA[k*BLOCK_WIDTH +: BLOCK_WIDTH]} +
                            {1'b0, iB[k*BLOCK_WIDTH +: BLOCK_WIDTH]};
            assign w_sum1 = {1'b0, iA[k*BLOCK_WIDTH +: BLOCK_WIDTH]} +
                            {1'b0, iB[k*BLOCK_WIDTH +: BLOCK_WIDTH]} +
                            {{BLOCK_WIDTH{1'b0}}, 1'b1};

            assign {w_carry[k+1], oSum[k*BLOCK_WIDTH +: BLOCK_WIDTH]} =
               w_carry[k] ? w_sum1 : w_sum0;
         end

         assign oCout = w_carry[N_BLOCKS];
      end else begin : g_ripple
         assign {oCout, oSum} = {1'b0, iA} + {1'b0, iB} + {{WIDTH{1'b0}}, iCin};
      end
   endgenerate

endmodule : carry_select_adder_ripple
`default_nettype wire

// File: rtl/mp_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : mp_subtractor
//  Description : Word-serial multi-precision unsigned subtractor. Computes
//                A - B as A + ~B + 1, one ADDER_WIDTH word per clock, least
//                significant word first, through a single word adder.
//  Ports       : iClk    - clock, rising edge
//                iRst    - asynchronous active-high reset
//                iStart  - start request, sampled only in IDLE
//                iOpA    - minuend (unsigned)
//                iOpB    - subtrahend (unsigned)
//                oRes    - (A - B) mod 2^OPERAND_WIDTH
//                oBorrow - 1 when A < B
//                oBusy   - high whenever the sequencer is not in IDLE
//                oDone   - one-cycle pulse; oRes/oBorrow valid while high
//  Revision    : 1.0 - initial release
// ============================================================================
module mp_subtractor
   import mp_arith_pkg::*;
#(
   parameter int unsigned OPERAND_WIDTH = MP_OPERAND_WIDTH,
   parameter int unsigned ADDER_WIDTH   = MP_ADDER_WIDTH,
   parameter int unsigned N_ITERATIONS  = OPERAND_WIDTH / ADDER_WIDTH
) (
   input  logic                     iClk,
   input  logic                     iRst,
   input  logic                     iStart,
   input  logic [OPERAND_WIDTH-1:0] iOpA,
   input  logic [OPERAND_WIDTH-1:0] iOpB,
   output logic [OPERAND_WIDTH-1:0] oRes,
   output logic                     oBorrow,
   output logic                     oBusy,
   output logic                     oDone
);

   localparam int unsigned CNT_W = $clog2(N_ITERATIONS) + 1;

   localparam logic [CNT_W-1:0] c_lastWord = CNT_W'(N_ITERATIONS - 1);
   localparam logic [CNT_W-1:0] c_cntOne   = CNT_W'(1);

   mp_state_t                r_state;
   mp_state_t                w_stateNext;
   logic [CNT_W-1:0]         r_cnt;
   logic [OPERAND_WIDTH-1:0] r_opA;
   logic [OPERAND_WIDTH-1:0] r_opB;
   logic [OPERAND_WIDTH-1:0] r_res;
   logic                     r_carry;
   logic                     r_borrow;

   logic                     w_isSub;
   logic                     w_lastWord;
   logic                     w_cin;
   logic [ADDER_WIDTH-1:0]   w_sum;
   logic                     w_cout;
   logic [OPERAND_WIDTH-1:0] w_resNext;

   assign w_isSub    = (r_state == SUB_FIRST) || (r_state == SUB_WORDS);
   // The counter equals the index of the word being processed; in SUB_FIRST
   // it is 0, so a single-word operand is detected as last immediately.
   assign w_lastWord = w_isSub && (r_cnt == c_lastWord);
   // Word 0 gets the +1 of the two's complement; later words chain the carry.
   assign w_cin      = (r_state == SUB_FIRST) ? 1'b1 : r_carry;

   carry_select_adder_ripple #(
      .WIDTH       (ADDER_WIDTH),
      .BLOCK_WIDTH (MP_CSA_BLOCK_WIDTH)
   ) u_adder (
      .iA    (r_opA[ADDER_WIDTH-1:0]),
      .iB    (~r_opB[ADDER_WIDTH-1:0]),
      .iCin  (w_cin),
      .oSum  (w_sum),
      .oCout (w_cout)
   );

   // New sum word enters at the top; after N_ITERATIONS shifts word 0 has
   // reached the bottom of the result register.
   generate
      if (N_ITERATIONS > 1) begin : g_resMulti
         assign w_resNext = {w_sum, r_res[OPERAND_WIDTH-1:ADDER_WIDTH]};
      end else begin : g_resSingle
         assign w_resNext = w_sum;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_stateNext = r_state;
      unique case (r_state)
         IDLE: begin
            if (iStart) begin
               w_stateNext = SUB_FIRST;
            end
         end
         SUB_FIRST, SUB_WORDS: begin
            w_stateNext = w_lastWord ? DONE : SUB_WORDS;
         end
         DONE: begin
            w_stateNext = IDLE;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_cnt    <= '0;
         r_opA    <= '0;
         r_opB    <= '0;
         r_res    <= '0;
         r_carry  <= 1'b0;
         r_borrow <= 1'b0;
      end else if ((r_state == IDLE) && iStart) begin
         r_cnt <= '0;
         r_opA <= iOpA;
         r_opB <= iOpB;
      end else if (w_isSub) begin
         r_cnt   <= r_cnt + c_cntOne;
         r_opA   <= r_opA >> ADDER_WIDTH;
         r_opB   <= r_opB >> ADDER_WIDTH;
         r_res   <= w_resNext;
         r_carry <= w_cout;
         // No carry out of A + ~B + 1 means B was larger than A.
         if (w_lastWord) begin
            r_borrow <= ~w_cout;
         end
      end
   end

   assign oRes    = r_res;
   assign oBorrow = r_borrow;
   assign oBusy   = (r_state != IDLE);
   assign oDone   = (r_state == DONE);

endmodule : mp_subtractor
`default_nettype wire

// File: tb/tb_mp_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mp_subtractor
//  Description : Directed self-checking bench for mp_subtractor at
//                OPERAND_WIDTH=512, ADDER_WIDTH=64.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mp_subtractor;

   localparam int unsigned OW = 512;
   localparam int unsigned AW = 64;

   logic          iClk;
   logic          iRst;
   logic          iStart;
   logic [OW-1:0] iOpA;
   logic [OW-1:0] iOpB;
   logic [OW-1:0] oRes;
   logic          oBorrow;
   logic          oBusy;
   logic          oDone;

   int            checkCount;
   int            errorCount;
   int            doneTotal;
   int            doneBase;

   logic [OW-1:0] allOnes;
   logic [OW-1:0] twoPow64;
   logic [OW-1:0] lowWordOnes;

   mp_subtractor #(
      .OPERAND_WIDTH (OW),
      .ADDER_WIDTH   (AW)
   ) dut (
      .iClk    (iClk),
      .iRst    (iRst),
      .iStart  (iStart),
      .iOpA    (iOpA),
      .iOpB    (iOpB),
      .oRes    (oRes),
      .oBorrow (oBorrow),
      .oBusy   (oBusy),
      .oDone   (oDone)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   // Counts every cycle spent with oDone high.
   initial doneTotal = 0;
   always @(negedge iClk) begin
      if (oDone) doneTotal++;
   end

   task automatic checkValue(input string tag, input logic [OW-1:0] observed,
                             input logic [OW-1:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic startOp(input logic [OW-1:0] a, input logic [OW-1:0] b);
      @(negedge iClk);
      iOpA   = a;
      iOpB   = b;
      iStart = 1'b1;
      @(posedge iClk);
      #1 iStart = 1'b0;
   endtask

   task automatic runOp(input string tag, input logic [OW-1:0] a,
                        input logic [OW-1:0] b, input logic [OW-1:0] expRes,
                        input logic expBorrow);
      int  edges;
      bit  seenDone;
      startOp(a, b);
      checkValue({tag, "_busy_run"}, OW'(oBusy), OW'(1));
      edges    = 0;
      seenDone = 1'b0;
      while (!seenDone && edges < 20) begin
         @(posedge iClk);
         #1;
         edges++;
         if (oDone) seenDone = 1'b1;
      end
      checkValue({tag, "_latency"}, OW'(edges), OW'(8));
      checkValue({tag, "_res"}, oRes, expRes);
      checkValue({tag, "_borrow"}, OW'(oBorrow), OW'(expBorrow));
      @(posedge iClk);
      #1;
      checkValue({tag, "_busy_after"}, OW'(oBusy), OW'(0));
      checkValue({tag, "_done_after"}, OW'(oDone), OW'(0));
      checkValue({tag, "_res_hold"}, oRes, expRes);
   endtask

   initial begin
      checkCount  = 0;
      errorCount  = 0;
      allOnes     = '1;
      twoPow64    = OW'(1) << 64;
      lowWordOnes = {{(OW-AW){1'b0}}, {AW{1'b1}}};
      iRst        = 1'b1;
      iStart      = 1'b0;
      iOpA        = '0;
      iOpB        = '0;

      repeat (3) @(posedge iClk);
      @(negedge iClk);
      checkValue("rst_res", oRes, '0);
      checkValue("rst_borrow", OW'(oBorrow), OW'(0));
      checkValue("rst_busy", OW'(oBusy), OW'(0));
      checkValue("rst_done", OW'(oDone), OW'(0));
      @(posedge iClk);
      #1 iRst = 1'b0;

      runOp("a5_b3", OW'(5), OW'(3), OW'(2), 1'b0);
      runOp("a0_b1", OW'(0), OW'(1), allOnes, 1'b1);
      runOp("a2p64_b1", twoPow64, OW'(1), lowWordOnes, 1'b0);
      runOp("ones_ones", allOnes, allOnes, '0, 1'b0);
      runOp("a1_ones", OW'(1), allOnes, OW'(2), 1'b1);

      // A start request in the middle of an operation must be ignored.
      doneBase = doneTotal;
      startOp(OW'(100), OW'(1));
      repeat (2) @(posedge iClk);
      #1;
      iOpA   = OW'(7);
      iOpB   = OW'(7);
      iStart = 1'b1;
      @(posedge iClk);
      #1 iStart = 1'b0;
      repeat (14) @(posedge iClk);
      #1;
      checkValue("ignore_done_cnt", OW'(doneTotal - doneBase), OW'(1));
      checkValue("ignore_res", oRes, OW'(99));
      checkValue("ignore_borrow", OW'(oBorrow), OW'(0));
      checkValue("ignore_busy", OW'(oBusy), OW'(0));

      // Reset after the 4th word edge aborts the operation silently.
      startOp(OW'(12345), OW'(67890));
      repeat (4) @(posedge iClk);
      #1 iRst = 1'b1;
      #1;
      checkValue("abort_res", oRes, '0);
      checkValue("abort_borrow", OW'(oBorrow), OW'(0));
      checkValue("abort_busy", OW'(oBusy), OW'(0));
      checkValue("abort_done", OW'(oDone), OW'(0));
      @(posedge iClk);
      #1 iRst = 1'b0;
      doneBase = doneTotal;
      repeat (12) @(posedge iClk);
      #1;
      checkValue("abort_no_done", OW'(doneTotal - doneBase), OW'(0));
      checkValue("abort_idle", OW'(oBusy), OW'(0));

      runOp("a9_b4", OW'(9), OW'(4), OW'(5), 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule : tb_mp_subtractor
`default_nettype wire
